// File: rtl/sel_arb_mux.sv
// rtl/sel_arb_mux.sv - N-input registered mux with direct, fixed-priority and round-robin grant
module sel_arb_mux #(
  parameter int WIDTH = 16,
  parameter int N     = 5,
  parameter int SELW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [1:0]         mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PTRW = $clog2(N);

  localparam logic [1:0] MODE_PRIO = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;

  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_word;
  logic [2*N-1:0]   valid_dbl;
  logic [N-1:0]     valid_rot;
  logic             accept;
  logic             xfer;
  int               rr_idx;

  // Grant selection; the round-robin case rotates in_valid so that bit 0 is the channel at ptr
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    valid_dbl = {in_valid, in_valid};
    valid_rot = N'(valid_dbl >> ptr_q);
    rr_idx    = 0;
    case (mode)
      MODE_PRIO: begin
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(i);
          end
        end
      end
      MODE_RR: begin
        for (int k = N - 1; k >= 0; k--) begin
          if (valid_rot[k]) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= N) rr_idx = rr_idx - N;
            gnt_vld = 1'b1;
            gnt_idx = SELW'(rr_idx);
          end
        end
      end
      default: begin
        // Mode 00 and 11: direct select; sel values beyond the last channel never match
        for (int i = 0; i < N; i++) begin
          if (sel == SELW'(i) && in_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(i);
          end
        end
      end
    endcase
  end

  // Word of the granted channel
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) gnt_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = !out_valid_q || out_ready;
  assign xfer   = gnt_vld && accept && !rst;

  // One-hot ready towards the granted producer only
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (gnt_idx == SELW'(i));
    end
  end

  // Next state of the output buffer and round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_word;
      out_src_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        if (int'(gnt_idx) == N - 1) ptr_d = '0;
        else                        ptr_d = PTRW'(gnt_idx) + PTRW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any buffered word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sel_arb_mux.sv
// tb/tb_sel_arb_mux.sv - scoreboard bench for sel_arb_mux
module tb_sel_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  in_ready;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic [15:0] out_data;
  logic [2:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] d [5] = '{16'd400, 16'd974, 16'd1024, 16'd2059, 16'd4097};
  int          rr_seq [7] = '{0, 1, 2, 3, 4, 0, 1};

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [18:0] sb [$];

  always #5 clk = ~clk;

  assign in_data = {d[4], d[3], d[2], d[1], d[0]};

  sel_arb_mux #(.WIDTH(16), .N(5), .SELW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic [4:0] v, input logic [1:0] m, input logic [2:0] s,
                      input logic ordy, input logic [4:0] er, input string name);
    @(posedge clk);
    #1;
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    #1;
    chk(name, 32'(in_ready), 32'(er));
    for (int i = 0; i < 5; i++) begin
      if (er[i]) sb.push_back({3'(i), d[i]});
    end
  endtask

  // Monitor: every word consumed downstream is compared against the scoreboard head
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("mon_data", 32'(out_data), 32'(e[15:0]));
          chk("mon_src", 32'(out_src), 32'(e[18:16]));
        end
      end
    end
  end

  initial begin
    logic [4:0] er;
    rst       = 1'b1;
    in_valid  = 5'h1f;
    mode      = 2'b00;
    sel       = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    in_valid = 5'h00;
    rst      = 1'b0;

    // Direct select sel = 0..5
    for (int s = 0; s < 6; s++) begin
      er = (s < 5) ? 5'(1 << s) : 5'b00000;
      step(5'h1f, 2'b00, 3'(s), 1'b1, er, "direct_rdy");
    end
    step(5'h00, 2'b00, 3'd0, 1'b1, 5'b00000, "direct_drain_rdy");
    chk("direct_sel5_valid", 32'(out_valid), 32'd0);

    // Fixed priority with channels 1, 2, 4 valid
    repeat (4) step(5'b10110, 2'b01, 3'd0, 1'b1, 5'b00010, "fixed_rdy");
    step(5'h00, 2'b01, 3'd0, 1'b1, 5'b00000, "fixed_drain_rdy");

    // Round-robin across all channels, wrapping after channel 4
    for (int k = 0; k < 7; k++) begin
      step(5'h1f, 2'b10, 3'd0, 1'b1, 5'(1 << rr_seq[k]), "rr_rdy");
    end

    // Mode switch with ptr at 2
    step(5'h1f, 2'b01, 3'd0, 1'b1, 5'b00001, "sw_fixed_rdy");
    step(5'h1f, 2'b10, 3'd0, 1'b1, 5'b00100, "sw_rr_rdy");

    // Reset mid-stream with channel 2 buffered and ptr at 3
    step(5'h00, 2'b10, 3'd0, 1'b0, 5'b00000, "pre_rst_rdy");
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_src", 32'(out_src), 32'd2);
    #1;
    in_valid  = 5'h1f;
    out_ready = 1'b1;
    rst       = 1'b1;
    sb.delete();
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_src", 32'(out_src), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 5'h00;
    rst      = 1'b0;
    step(5'h1f, 2'b10, 3'd0, 1'b1, 5'b00001, "rr_after_rst_rdy");
    step(5'h00, 2'b00, 3'd0, 1'b1, 5'b00000, "rst_drain_rdy");

    // Backpressure
    step(5'b01000, 2'b00, 3'd3, 1'b1, 5'b01000, "bp_load_rdy");
    repeat (3) begin
      step(5'b10000, 2'b00, 3'd4, 1'b0, 5'b00000, "bp_stall_rdy");
      chk("bp_stall_data", 32'(out_data), 32'd2059);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    step(5'b10000, 2'b00, 3'd4, 1'b1, 5'b10000, "bp_release_rdy");
    chk("bp_release_data", 32'(out_data), 32'd2059);
    step(5'h00, 2'b00, 3'd0, 1'b1, 5'b00000, "bp_drain_rdy");
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    chk("bp_new_data", 32'(out_data), 32'd4097);
    chk("bp_new_src", 32'(out_src), 32'd4);
    step(5'h00, 2'b00, 3'd0, 1'b1, 5'b00000, "idle_rdy");
    chk("idle_valid", 32'(out_valid), 32'd0);

    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
